// File: rtl/ma_stage.sv
// Memory-access pipeline stage: passes ALU results through and runs one
// load/store at a time over a req/ack data-memory port, with a request timeout.
package ma_pkg;
   typedef struct packed {
      logic isLd;
      logic isSt;
      logic isWb;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] aluresult;
      logic [31:0] op2;
      logic [31:0] instr;
      ctrl_t       ctrl;
   } Ex_Ma_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] aluresult;
      logic [31:0] ldresult;
      logic [31:0] instr;
      ctrl_t       ctrl;
   } Ma_Rw_t;
endpackage

module ma_stage
   import ma_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  Ex_Ma_t      Ex_Payld_i,
   input  logic        Ex_Valid_i,
   output logic        Ex_Ready_o,
   output Ma_Rw_t      Ma_Payld_o,
   output logic        Ma_Valid_o,
   input  logic        Ma_Ready_i,
   output logic        Dmem_Req_o,
   output logic        Dmem_We_o,
   output logic [31:0] Dmem_Addr_o,
   output logic [31:0] Dmem_Wdata_o,
   input  logic        Dmem_Ack_i,
   input  logic [31:0] Dmem_Rdata_i,
   output logic        Ma_Err_o
);

   typedef enum logic {IDLE, REQ} state_e;

   // cnt_q counts completed request cycles, so the last allowed one sees N-1
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e      state_q, state_d;
   Ma_Rw_t      out_q, out_d;
   Ma_Rw_t      pend_q, pend_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   logic        ex_ready, accept, is_mem, misal, timeout;
   Ma_Rw_t      in_rw;

   always_comb begin
      ex_ready = (state_q == IDLE) && (!valid_q || Ma_Ready_i);
      accept   = Ex_Valid_i && ex_ready;
      is_mem   = Ex_Payld_i.ctrl.isLd || Ex_Payld_i.ctrl.isSt;
      misal    = Ex_Payld_i.aluresult[1:0] != 2'b00;
      timeout  = (state_q == REQ) && !Dmem_Ack_i && (cnt_q == TMO_LAST);
      in_rw    = '{pc: Ex_Payld_i.pc, aluresult: Ex_Payld_i.aluresult,
                   ldresult: 32'h0, instr: Ex_Payld_i.instr,
                   ctrl: Ex_Payld_i.ctrl};

      state_d = state_q;
      out_d   = out_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (valid_q && Ma_Ready_i) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_mem && !misal) begin
                  state_d = REQ;
                  pend_d  = in_rw;
                  req_d   = 1'b1;
                  we_d    = Ex_Payld_i.ctrl.isSt;
                  addr_d  = {Ex_Payld_i.aluresult[31:2], 2'b00};
                  wdata_d = Ex_Payld_i.op2;
                  cnt_d   = '0;
               end else begin
                  out_d   = in_rw;
                  valid_d = 1'b1;
                  if (is_mem) err_d = 1'b1;
               end
            end
         end
         REQ: begin
            if (Dmem_Ack_i || timeout) begin
               state_d = IDLE;
               req_d   = 1'b0;
               out_d   = pend_q;
               out_d.ldresult = (Dmem_Ack_i && pend_q.ctrl.isLd) ? Dmem_Rdata_i : 32'h0;
               valid_d = 1'b1;
               if (!Dmem_Ack_i) err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         pend_q  <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign Ex_Ready_o   = ex_ready;
   assign Ma_Payld_o   = out_q;
   assign Ma_Valid_o   = valid_q;
   assign Dmem_Req_o   = req_q;
   assign Dmem_We_o    = we_q;
   assign Dmem_Addr_o  = addr_q;
   assign Dmem_Wdata_o = wdata_q;
   assign Ma_Err_o     = err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: directed vectors, an in-order retirement model checked
// every cycle, and literal expectations for each scenario.
module tb_ma_stage;
   import ma_pkg::*;

   localparam int unsigned TMO = 4;

   logic        Clk = 1'b0;
   logic        Rst;
   Ex_Ma_t      ex_p;
   logic        ex_v;
   logic        ex_rdy;
   Ma_Rw_t      ma_p;
   logic        ma_v;
   logic        ma_ready;
   logic        req, we, ack, err;
   logic [31:0] addr, wdata, rdata;

   ma_stage #(.MEM_TIMEOUT(TMO)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Ex_Payld_i   (ex_p),
      .Ex_Valid_i   (ex_v),
      .Ex_Ready_o   (ex_rdy),
      .Ma_Payld_o   (ma_p),
      .Ma_Valid_o   (ma_v),
      .Ma_Ready_i   (ma_ready),
      .Dmem_Req_o   (req),
      .Dmem_We_o    (we),
      .Dmem_Addr_o  (addr),
      .Dmem_Wdata_o (wdata),
      .Dmem_Ack_i   (ack),
      .Dmem_Rdata_i (rdata),
      .Ma_Err_o     (err)
   );

   always #5 Clk = ~Clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic        chk_en  = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endfunction

   function automatic Ex_Ma_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] op2, input logic ld, input logic st);
      Ex_Ma_t e;
      e.pc        = pc;
      e.aluresult = alu;
      e.op2       = op2;
      e.instr     = pc ^ 32'hA5A5_0000;
      e.ctrl.isLd = ld;
      e.ctrl.isSt = st;
      e.ctrl.isWb = !st;
      return e;
   endfunction

   // Memory responder: acks in the ack_at-th cycle of a request (0 = never)
   int unsigned ack_at = 0;
   logic [31:0] rd_val = '0;
   int unsigned req_cyc = 0, last_req_len = 0, req_total = 0, rdy_in_req = 0;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wdata;

   initial begin
      ack   = 1'b0;
      rdata = '0;
      forever begin
         @(posedge Clk);
         #2;
         if (req) begin
            req_cyc++;
            req_total++;
            if (ex_rdy) rdy_in_req++;
            if (req_cyc == 1) begin
               cap_we    = we;
               cap_addr  = addr;
               cap_wdata = wdata;
            end
         end else begin
            if (req_cyc != 0) last_req_len = req_cyc;
            req_cyc = 0;
         end
         ack   = req && (ack_at != 0) && (req_cyc == ack_at);
         rdata = rd_val;
      end
   end

   // Reference model: one instruction retires per accept, in order; a memory
   // op retires the cycle after its ack, or after TMO unanswered request cycles.
   Ma_Rw_t exp_q[$];
   Ma_Rw_t ret_q[$];

   function automatic Ma_Rw_t as_ret(input Ex_Ma_t e, input logic [31:0] ld);
      Ma_Rw_t r;
      r.pc        = e.pc;
      r.aluresult = e.aluresult;
      r.ldresult  = ld;
      r.instr     = e.instr;
      r.ctrl      = e.ctrl;
      return r;
   endfunction

   initial begin
      Ex_Ma_t      pend;
      logic        mem_pend, err_exp, exp_ready, is_mem;
      int unsigned req_len;
      mem_pend = 1'b0;
      err_exp  = 1'b0;
      req_len  = 0;
      pend     = '0;
      forever begin
         @(negedge Clk);
         if (!Rst || !chk_en) begin
            exp_q.delete();
            mem_pend = 1'b0;
            err_exp  = 1'b0;
            req_len  = 0;
         end else begin
            exp_ready = !mem_pend && (exp_q.size() == 0 || ma_ready);
            chk("valid", 32'(ma_v), 32'(exp_q.size() != 0));
            if (ma_v && exp_q.size() != 0) begin
               chk("out_pc",  ma_p.pc,        exp_q[0].pc);
               chk("out_alu", ma_p.aluresult, exp_q[0].aluresult);
               chk("out_ld",  ma_p.ldresult,  exp_q[0].ldresult);
               chk("out_ins", ma_p.instr,     exp_q[0].instr);
               chk("out_ctl", 32'(ma_p.ctrl), 32'(exp_q[0].ctrl));
            end
            chk("err",      32'(err),    32'(err_exp));
            chk("ex_ready", 32'(ex_rdy), 32'(exp_ready));
            chk("req",      32'(req),    32'(mem_pend));
            chk("addr_lsb", 32'(addr[1:0]), 32'h0);
            if (mem_pend && req) begin
               chk("req_addr", addr,    pend.aluresult);
               chk("req_we",   32'(we), 32'(pend.ctrl.isSt));
               if (pend.ctrl.isSt) chk("req_wdata", wdata, pend.op2);
            end

            if (ma_v && ma_ready) begin
               ret_q.push_back(ma_p);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (mem_pend) begin
               req_len++;
               if (ack) begin
                  exp_q.push_back(as_ret(pend, pend.ctrl.isLd ? rdata : 32'h0));
                  mem_pend = 1'b0;
               end else if (req_len == TMO) begin
                  exp_q.push_back(as_ret(pend, 32'h0));
                  err_exp  = 1'b1;
                  mem_pend = 1'b0;
               end
            end
            if (ex_v && exp_ready) begin
               is_mem = ex_p.ctrl.isLd || ex_p.ctrl.isSt;
               if (is_mem && ex_p.aluresult[1:0] == 2'b00) begin
                  pend     = ex_p;
                  mem_pend = 1'b1;
                  req_len  = 0;
               end else begin
                  exp_q.push_back(as_ret(ex_p, 32'h0));
                  if (is_mem) err_exp = 1'b1;
               end
            end
         end
      end
   end

   task automatic send(input Ex_Ma_t p, output int unsigned waits);
      waits = 0;
      ex_p  = p;
      ex_v  = 1'b1;
      @(negedge Clk);
      while (!ex_rdy && waits < 50) begin
         waits++;
         @(negedge Clk);
      end
      if (!ex_rdy) fail_now("send_accept");
      @(posedge Clk);
      #1;
      ex_v = 1'b0;
   endtask

   task automatic wait_ret(input int unsigned n);
      int unsigned k = 0;
      while (ret_q.size() < n && k < 100) begin
         @(negedge Clk);
         k++;
      end
      if (ret_q.size() < n) fail_now("wait_retire");
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int unsigned w, base;
      Rst      = 1'b0;
      ex_v     = 1'b0;
      ex_p     = '0;
      ma_ready = 1'b1;
      #12;
      chk("rst_valid", 32'(ma_v),   32'h0);
      chk("rst_payld", ma_p.aluresult | ma_p.pc | ma_p.ldresult | ma_p.instr, 32'h0);
      chk("rst_req",   32'(req),    32'h0);
      chk("rst_we",    32'(we),     32'h0);
      chk("rst_addr",  addr,        32'h0);
      chk("rst_wdata", wdata,       32'h0);
      chk("rst_err",   32'(err),    32'h0);
      chk("rst_ready", 32'(ex_rdy), 32'h1);
      @(posedge Clk);
      #1;
      Rst    = 1'b1;
      chk_en = 1'b1;

      // Back-to-back ALU ops
      ret_q.delete();
      base = req_total;
      for (int unsigned i = 0; i < 4; i++) begin
         send(mk(32'h1000 + 4 * i, 32'h11 * (i + 1), 32'h0, 1'b0, 1'b0), w);
         chk("alu_nowait", w, 0);
      end
      wait_ret(4);
      chk("alu0", ret_q[0].aluresult, 32'h11);
      chk("alu1", ret_q[1].aluresult, 32'h22);
      chk("alu2", ret_q[2].aluresult, 32'h33);
      chk("alu3", ret_q[3].aluresult, 32'h44);
      chk("alu_noreq", req_total - base, 0);

      // Load, ack in the third request cycle
      ret_q.delete();
      ack_at     = 3;
      rd_val     = 32'hCAFE_F00D;
      rdy_in_req = 0;
      send(mk(32'h2000, 32'h100, 32'h0, 1'b1, 1'b0), w);
      wait_ret(1);
      chk("ld_len",   last_req_len, 3);
      chk("ld_we",    32'(cap_we), 32'h0);
      chk("ld_addr",  cap_addr, 32'h100);
      chk("ld_data",  ret_q[0].ldresult, 32'hCAFE_F00D);
      chk("ld_stall", rdy_in_req, 0);

      // Store, ack in the first request cycle
      ret_q.delete();
      ack_at = 1;
      rd_val = 32'hDEAD_BEEF;
      send(mk(32'h2004, 32'h40, 32'h1234_5678, 1'b0, 1'b1), w);
      wait_ret(1);
      chk("st_len",   last_req_len, 1);
      chk("st_we",    32'(cap_we), 32'h1);
      chk("st_wdata", cap_wdata, 32'h1234_5678);
      chk("st_ld0",   ret_q[0].ldresult, 32'h0);

      // Backpressure: hold 5 cycles, release accepts the waiting op at once
      ret_q.delete();
      ma_ready = 1'b0;
      send(mk(32'h3000, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0), w);
      ex_p = mk(32'h3004, 32'hAAAA_0002, 32'h0, 1'b0, 1'b0);
      ex_v = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("bp_hold",  ma_p.aluresult, 32'hAAAA_0001);
         chk("bp_valid", 32'(ma_v),   32'h1);
         chk("bp_ready", 32'(ex_rdy), 32'h0);
      end
      @(posedge Clk);
      #1;
      ma_ready = 1'b1;
      send(mk(32'h3004, 32'hAAAA_0002, 32'h0, 1'b0, 1'b0), w);
      chk("bp_release", w, 0);
      wait_ret(2);
      chk("bp_first",  ret_q[0].aluresult, 32'hAAAA_0001);
      chk("bp_second", ret_q[1].aluresult, 32'hAAAA_0002);

      // Ack in the last allowed cycle beats the timeout
      ret_q.delete();
      ack_at = TMO;
      rd_val = 32'h0BAD_F00D;
      send(mk(32'h4000, 32'h80, 32'h0, 1'b1, 1'b0), w);
      wait_ret(1);
      chk("edge_len",  last_req_len, TMO);
      chk("edge_data", ret_q[0].ldresult, 32'h0BAD_F00D);
      chk("edge_err",  32'(err), 32'h0);

      // Timeout
      ret_q.delete();
      ack_at = 0;
      send(mk(32'h5000, 32'h200, 32'h0, 1'b1, 1'b0), w);
      wait_ret(1);
      chk("tmo_len", last_req_len, TMO);
      chk("tmo_ld0", ret_q[0].ldresult, 32'h0);
      chk("tmo_err", 32'(err), 32'h1);
      send(mk(32'h5004, 32'h5, 32'h0, 1'b0, 1'b0), w);
      wait_ret(2);
      chk("tmo_err_sticky", 32'(err), 32'h1);

      // Reset in the middle of a request
      ack_at = 0;
      send(mk(32'h6000, 32'h300, 32'h0, 1'b1, 1'b0), w);
      #3;
      chk("mid_req_hi", 32'(req), 32'h1);
      Rst = 1'b0;
      #1;
      chk("mid_req",   32'(req),    32'h0);
      chk("mid_addr",  addr,        32'h0);
      chk("mid_valid", 32'(ma_v),   32'h0);
      chk("mid_err",   32'(err),    32'h0);
      chk("mid_ready", 32'(ex_rdy), 32'h1);
      @(posedge Clk);
      #1;
      Rst = 1'b1;

      // Misaligned load
      ret_q.delete();
      base = req_total;
      send(mk(32'h7000, 32'h102, 32'h0, 1'b1, 1'b0), w);
      wait_ret(1);
      chk("mis_noreq", req_total - base, 0);
      chk("mis_ld0",   ret_q[0].ldresult, 32'h0);
      chk("mis_err",   32'(err), 32'h1);

      repeat (3) @(posedge Clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      fail_now("global_timeout");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "simulation time limit");
   end

endmodule
